// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: NM masters share one slave, one transfer per grant,
// with a per-transfer wait-state timeout that returns a bus error to the owner.
module wb_rr_arbiter #(
  parameter int NM      = 4,
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [NM-1:0]        m_stb_i,
  input  logic [NM-1:0]        m_we_i,
  input  logic [NM*AW-1:0]     m_adr_i,
  input  logic [NM*DW-1:0]     m_dat_i,
  input  logic [NM*DW/8-1:0]   m_sel_i,
  output logic [NM-1:0]        m_ack_o,
  output logic [NM-1:0]        m_err_o,
  output logic [DW-1:0]        m_dat_o,
  output logic                 s_stb_o,
  output logic                 s_we_o,
  output logic [AW-1:0]        s_adr_o,
  output logic [DW-1:0]        s_dat_o,
  output logic [DW/8-1:0]      s_sel_o,
  input  logic                 s_ack_i,
  input  logic [DW-1:0]        s_dat_i,
  output logic [NM-1:0]        gnt_o
);

  localparam int          PW  = (NM > 1) ? $clog2(NM) : 1;
  localparam int unsigned NMU = NM;
  localparam int unsigned AWU = AW;
  localparam int unsigned DWU = DW;
  localparam int unsigned SWU = DW / 8;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   owner;
  logic [PW-1:0]   owner_next;
  logic [PW-1:0]   pick;
  logic [NM-1:0]   pick_oh;
  logic            found;
  logic [7:0]      wait_cnt;
  logic            busy;
  logic            own_stb;
  logic            own_we;
  logic            xfer_ack;
  logic            tmo;
  int unsigned     cand;

  // Search starts at ptr and wraps, so the last-served master has lowest priority.
  always_comb begin
    found   = 1'b0;
    pick    = '0;
    pick_oh = '0;
    cand    = 0;
    for (int unsigned i = 0; i < NMU; i++) begin
      cand = 32'(ptr) + i;
      if (cand >= NMU) cand = cand - NMU;
      if (!found && m_stb_i[cand[PW-1:0]]) begin
        found = 1'b1;
        pick  = cand[PW-1:0];
      end
    end
    pick_oh[pick] = found;
  end

  assign busy     = (state == BUSY);
  assign own_stb  = busy & |(m_stb_i & gnt_o);
  assign own_we   = busy & |(m_we_i & gnt_o);
  assign s_stb_o  = own_stb;
  assign s_we_o   = own_we;
  assign xfer_ack = s_ack_i & own_stb;
  // Timeout fires in the cycle the counter would reach TIMEOUT; an ack wins.
  assign tmo      = own_stb & ~s_ack_i & (wait_cnt == 8'(TIMEOUT - 1));
  assign m_ack_o  = gnt_o & {NM{xfer_ack}};
  assign m_err_o  = gnt_o & {NM{tmo}};
  assign m_dat_o  = s_dat_i;

  assign owner_next = (owner == PW'(NM - 1)) ? '0 : owner + 1'b1;

  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    for (int unsigned k = 0; k < NMU; k++) begin
      if (busy && gnt_o[k]) begin
        s_adr_o = m_adr_i[k*AWU +: AW];
        s_dat_o = m_dat_i[k*DWU +: DW];
        s_sel_o = m_sel_i[k*SWU +: DW/8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= IDLE;
      gnt_o    <= '0;
      owner    <= '0;
      ptr      <= '0;
      wait_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state    <= BUSY;
            gnt_o    <= pick_oh;
            owner    <= pick;
            wait_cnt <= '0;
          end
        end
        BUSY: begin
          if (!own_stb || xfer_ack || tmo) begin
            state <= IDLE;
            gnt_o <= '0;
            ptr   <= owner_next;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          gnt_o <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter: per-cycle vector table plus hand-written
// sequences for address/data forwarding and asynchronous reset mid-transfer.
module tb_wb_rr_arbiter;

  localparam int NM = 4;
  localparam int DW = 32;
  localparam int AW = 32;

  logic              clk_i = 1'b0;
  logic              rst_n_i;
  logic [NM-1:0]     m_stb_i;
  logic [NM-1:0]     m_we_i;
  logic [NM*AW-1:0]  m_adr_i;
  logic [NM*DW-1:0]  m_dat_i;
  logic [NM*DW/8-1:0] m_sel_i;
  logic [NM-1:0]     m_ack_o;
  logic [NM-1:0]     m_err_o;
  logic [DW-1:0]     m_dat_o;
  logic              s_stb_o;
  logic              s_we_o;
  logic [AW-1:0]     s_adr_o;
  logic [DW-1:0]     s_dat_o;
  logic [DW/8-1:0]   s_sel_o;
  logic              s_ack_i;
  logic [DW-1:0]     s_dat_i;
  logic [NM-1:0]     gnt_o;

  wb_rr_arbiter #(.NM(NM), .DW(DW), .AW(AW), .TIMEOUT(4)) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .m_stb_i (m_stb_i),
    .m_we_i  (m_we_i),
    .m_adr_i (m_adr_i),
    .m_dat_i (m_dat_i),
    .m_sel_i (m_sel_i),
    .m_ack_o (m_ack_o),
    .m_err_o (m_err_o),
    .m_dat_o (m_dat_o),
    .s_stb_o (s_stb_o),
    .s_we_o  (s_we_o),
    .s_adr_o (s_adr_o),
    .s_dat_o (s_dat_o),
    .s_sel_o (s_sel_o),
    .s_ack_i (s_ack_i),
    .s_dat_i (s_dat_i),
    .gnt_o   (gnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       rst_n;
    logic [3:0] stb;
    logic [3:0] we;
    logic       ack;
    logic [3:0] gnt;
    logic [3:0] mack;
    logic [3:0] merr;
    logic       sstb;
    logic       swe;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic rst_n, input logic [3:0] stb, input logic [3:0] we,
                              input logic ack, input logic [3:0] gnt, input logic [3:0] mack,
                              input logic [3:0] merr, input logic sstb, input logic swe);
    vec_t v;
    v.rst_n = rst_n; v.stb = stb; v.we = we; v.ack = ack;
    v.gnt = gnt; v.mack = mack; v.merr = merr; v.sstb = sstb; v.swe = swe;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  initial begin
    rst_n_i = 1'b0;
    m_stb_i = '0;
    m_we_i  = '0;
    s_ack_i = 1'b0;
    s_dat_i = 32'h0BAD_F00D;
    for (int k = 0; k < NM; k++) begin
      m_adr_i[k*AW +: AW]   = 32'h1000 + 32'(k) * 32'h10;
      m_dat_i[k*DW +: DW]   = 32'hA000_0000 + 32'(k);
      m_sel_i[k*4 +: 4]     = 4'(k + 1);
    end

    //                rst  stb      we       ack   gnt      mack     merr     sstb  swe
    // reset state
    vecs.push_back(mk(1'b0, 4'b1111, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0));
    // masters 0 and 2, ack one cycle after stb
    vecs.push_back(mk(1'b1, 4'b0101, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 4'b0101, 4'b0000, 1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 4'b0101, 4'b0000, 1'b1, 4'b0001, 4'b0001, 4'b0000, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 4'b0100, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 4'b0100, 4'b0000, 1'b0, 4'b0100, 4'b0000, 4'b0000, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 4'b0100, 4'b0000, 1'b1, 4'b0100, 4'b0100, 4'b0000, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0));
    // reset, then all four request continuously with ack held high
    vecs.push_back(mk(1'b0, 4'b1111, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 4'b1111, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 4'b1111, 4'b1111, 1'b1, 4'b0001, 4'b0001, 4'b0000, 1'b1, 1'b1));
    vecs.push_back(mk(1'b1, 4'b1111, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 4'b1111, 4'b0000, 1'b1, 4'b0010, 4'b0010, 4'b0000, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 4'b1111, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 4'b1111, 4'b0000, 1'b1, 4'b0100, 4'b0100, 4'b0000, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 4'b1111, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 4'b1111, 4'b0000, 1'b1, 4'b1000, 4'b1000, 4'b0000, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 4'b1111, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 4'b1111, 4'b0000, 1'b1, 4'b0001, 4'b0001, 4'b0000, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0));
    // timeout on master 1 in its 4th busy cycle, then ack coincident with timeout on master 2
    vecs.push_back(mk(1'b1, 4'b0110, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 4'b0110, 4'b0000, 1'b0, 4'b0010, 4'b0000, 4'b0000, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 4'b0110, 4'b0000, 1'b0, 4'b0010, 4'b0000, 4'b0000, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 4'b0110, 4'b0000, 1'b0, 4'b0010, 4'b0000, 4'b0000, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 4'b0110, 4'b0000, 1'b0, 4'b0010, 4'b0000, 4'b0010, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 4'b0110, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 4'b0110, 4'b0000, 1'b0, 4'b0100, 4'b0000, 4'b0000, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 4'b0110, 4'b0000, 1'b0, 4'b0100, 4'b0000, 4'b0000, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 4'b0110, 4'b0000, 1'b0, 4'b0100, 4'b0000, 4'b0000, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 4'b0110, 4'b0000, 1'b1, 4'b0100, 4'b0100, 4'b0000, 1'b1, 1'b0));
    // pointer at 3 wraps to master 1
    vecs.push_back(mk(1'b1, 4'b0010, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 4'b0010, 4'b0000, 1'b1, 4'b0010, 4'b0010, 4'b0000, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0));
    // ack held in idle is ignored; owner 2 drops stb mid-busy, pointer moves past it
    vecs.push_back(mk(1'b1, 4'b0100, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 4'b0100, 4'b0000, 1'b0, 4'b0100, 4'b0000, 4'b0000, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 4'b0000, 4'b0000, 1'b1, 4'b0100, 4'b0000, 4'b0000, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 4'b0101, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 4'b0101, 4'b0000, 1'b1, 4'b0001, 4'b0001, 4'b0000, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0));

    foreach (vecs[i]) begin
      @(posedge clk_i);
      #1;
      rst_n_i = vecs[i].rst_n;
      m_stb_i = vecs[i].stb;
      m_we_i  = vecs[i].we;
      s_ack_i = vecs[i].ack;
      @(negedge clk_i);
      check($sformatf("v%0d gnt", i),   64'(gnt_o),   64'(vecs[i].gnt));
      check($sformatf("v%0d m_ack", i), 64'(m_ack_o), 64'(vecs[i].mack));
      check($sformatf("v%0d m_err", i), 64'(m_err_o), 64'(vecs[i].merr));
      check($sformatf("v%0d s_stb", i), 64'(s_stb_o), 64'(vecs[i].sstb));
      check($sformatf("v%0d s_we", i),  64'(s_we_o),  64'(vecs[i].swe));
    end

    // Master 1 write forwarded to the slave (pointer is at 1 here)
    @(posedge clk_i);
    #1;
    m_adr_i[1*AW +: AW] = 32'h0000_0100;
    m_dat_i[1*DW +: DW] = 32'hDEAD_BEEF;
    m_sel_i[1*4 +: 4]   = 4'hF;
    m_stb_i = 4'b0010;
    m_we_i  = 4'b0010;
    s_ack_i = 1'b0;
    @(negedge clk_i);
    check("wr idle gnt", 64'(gnt_o), 64'h0);
    @(posedge clk_i);
    #1;
    s_ack_i = 1'b1;
    s_dat_i = 32'h1234_5678;
    @(negedge clk_i);
    check("wr gnt",   64'(gnt_o),   64'h2);
    check("wr s_adr", 64'(s_adr_o), 64'h0000_0100);
    check("wr s_dat", 64'(s_dat_o), 64'hDEAD_BEEF);
    check("wr s_sel", 64'(s_sel_o), 64'hF);
    check("wr s_we",  64'(s_we_o),  64'h1);
    check("wr s_stb", 64'(s_stb_o), 64'h1);
    check("wr m_ack", 64'(m_ack_o), 64'h2);
    check("m_dat",    64'(m_dat_o), 64'h1234_5678);
    @(posedge clk_i);
    #1;
    m_stb_i = '0;
    m_we_i  = '0;
    s_ack_i = 1'b0;
    @(negedge clk_i);
    check("wr done gnt", 64'(gnt_o), 64'h0);

    // Master 3 owns the bus (pointer at 2) when reset is pulsed asynchronously
    @(posedge clk_i);
    #1;
    m_stb_i = 4'b1001;
    m_we_i  = 4'b1001;
    @(negedge clk_i);
    check("rs idle gnt", 64'(gnt_o), 64'h0);
    @(negedge clk_i);
    check("rs busy gnt", 64'(gnt_o), 64'h8);
    check("rs busy s_stb", 64'(s_stb_o), 64'h1);
    #2;
    rst_n_i = 1'b0;
    s_ack_i = 1'b1;
    #1;
    check("rs gnt",   64'(gnt_o),   64'h0);
    check("rs m_ack", 64'(m_ack_o), 64'h0);
    check("rs m_err", 64'(m_err_o), 64'h0);
    check("rs s_stb", 64'(s_stb_o), 64'h0);
    check("rs s_we",  64'(s_we_o),  64'h0);
    check("rs s_adr", 64'(s_adr_o), 64'h0);
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    s_ack_i = 1'b0;
    @(negedge clk_i);
    check("rs post idle gnt", 64'(gnt_o), 64'h0);
    @(negedge clk_i);
    check("rs post gnt", 64'(gnt_o), 64'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_rr_arbiter.md
WB_RR_ARBITER -- requirements
Module: wb_rr_arbiter

Interface
REQ-001 The block SHALL have parameter NM, default 4, meaning number of masters (2..8).
REQ-002 The block SHALL have parameter DW, default 32, meaning data width.
REQ-003 The block SHALL have parameter AW, default 32, meaning address width.
REQ-004 The block SHALL have parameter TIMEOUT, default 255, meaning cycles without ack before bus error (1..255).
REQ-005 The block SHALL have port clk_i, input, 1, the only clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst_n_i, input, 1, asynchronous active-low reset.
REQ-007 The block SHALL have port m_stb_i, input, NM, per-master request/strobe.
REQ-008 The block SHALL have port m_we_i, input, NM, per-master write enable.
REQ-009 The block SHALL have port m_adr_i, input, NM*AW, packed master addresses; master k at [k*AW +: AW].
REQ-010 The block SHALL have port m_dat_i, input, NM*DW, packed master write data.
REQ-011 The block SHALL have port m_sel_i, input, NM*DW/8, packed byte selects.
REQ-012 The block SHALL have port m_ack_o, output, NM, per-master ack.
REQ-013 The block SHALL have port m_err_o, output, NM, per-master timeout error.
REQ-014 The block SHALL have port m_dat_o, output, DW, slave read data broadcast to all masters.
REQ-015 The block SHALL have port s_stb_o, s_we_o (1), s_adr_o (AW), s_dat_o (DW), s_sel_o (DW/8), all outputs, the forwarded request of the owner.
REQ-016 The block SHALL have ports s_ack_i (input, 1) and s_dat_i (input, DW), the slave response.
REQ-017 The block SHALL have port gnt_o, output, NM, one-hot registered grant.

Function
REQ-018 The block SHALL implement states IDLE and BUSY; reset state IDLE.
REQ-019 In IDLE with any m_stb_i set, the block SHALL select the first requester at or after priority pointer ptr (wrapping NM-1 -> 0), register its one-hot gnt_o, and enter BUSY at the next edge.
REQ-020 In IDLE with no request, gnt_o SHALL be 0 and the block SHALL stay in IDLE.
REQ-021 In BUSY, s_stb_o/s_we_o/s_adr_o/s_dat_o/s_sel_o SHALL combinationally equal the owner's inputs; outside BUSY s_stb_o and s_we_o SHALL be 0.
REQ-022 m_ack_o[owner] SHALL equal s_ack_i AND s_stb_o in the same cycle; all other m_ack_o bits SHALL be 0.
REQ-023 m_dat_o SHALL equal s_dat_i combinationally at all times.
REQ-024 On ack in BUSY, the block SHALL set ptr to owner+1 mod NM, clear gnt_o and return to IDLE at the next edge (one transfer per grant).
REQ-025 A grant SHALL take effect one cycle after request; a new grant after ack SHALL take at least one IDLE cycle.
REQ-026 An 8-bit wait counter SHALL clear on BUSY entry and increment each BUSY cycle without s_ack_i.
REQ-027 When the counter reaches TIMEOUT without ack, m_err_o[owner] SHALL pulse high for exactly that cycle, ptr SHALL advance as on ack, and the block SHALL return to IDLE.
REQ-028 Ack and timeout in the same cycle SHALL be treated as ack; m_err_o SHALL stay 0.
REQ-029 If the owner drops m_stb_i in BUSY before ack, the block SHALL return to IDLE next edge with ptr advanced and no ack/err.
REQ-030 s_ack_i arriving in IDLE SHALL be ignored (no m_ack_o, no state change).

Reset
REQ-031 On rst_n_i low, asynchronously: state=IDLE, gnt_o=0, ptr=0, counter=0, m_ack_o=0, m_err_o=0, s_stb_o=0, s_we_o=0.
REQ-032 Reset asserted mid-transfer SHALL abort it without ack or err; after release arbitration restarts from master 0.

Verification
REQ-033 Masters 0 and 2 request after reset, slave acks 1 cycle after stb -> master 0 granted and acked first, then master 2; gnt_o sequence 4'b0001, 0, 4'b0100.
REQ-034 All four masters request continuously, one-cycle ack -> grants rotate 0,1,2,3,0; no master served twice before others.
REQ-035 Master 1 writes adr 0x0000_0100, dat 0xDEAD_BEEF, sel 4'hF -> s_adr_o/s_dat_o/s_sel_o/s_we_o match exactly while gnt_o=4'b0010.
REQ-036 TIMEOUT=4, slave never acks -> m_err_o[owner] single-cycle pulse in 4th BUSY cycle, bus returns to IDLE, next master granted.
REQ-037 rst_n_i pulsed low during BUSY with master 3 owner -> all outputs zero immediately, no ack/err, next grant to lowest requester.
REQ-038 s_ack_i held high in IDLE and owner drops stb mid-BUSY -> no m_ack_o asserted, ptr advances past dropped owner.
